program_stream_receiver: RTL and testbench

Upstream front end for the program-load path of the CPU system. It accepts a byte stream through a valid/ready handshake and parses it as a header byte followed by big-endian 16-bit words. It drives the system's prog_data_in/prog_addr/prog_write_enable inputs with sequential addresses. Once the whole program is written and the system reports load_done, it issues a single start_execution pulse.

---
 rtl/program_load_pkg.sv | 19 +
 rtl/program_stream_receiver.sv | 120 ++++++++++++
 tb/tb_program_stream_receiver.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_load_pkg.sv
// Shared types and sizing for the program-load path.
package program_load_pkg;

    localparam int unsigned DATA_WIDTH   = 16;
    localparam int unsigned ADDR_WIDTH   = 5;
    localparam int unsigned MAX_WORDS    = 32;
    localparam int unsigned HEADER_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        WAIT_DONE,
        START,
        ERR
    } state_e;

endpackage

// File: rtl/program_stream_receiver.sv
// Parses a header byte plus big-endian 16-bit words from a byte stream,
// writes them to sequential program addresses, then pulses start_execution.
module program_stream_receiver
    import program_load_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [HEADER_WIDTH-1:0] byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    input  logic                    load_done,
    output logic [DATA_WIDTH-1:0]   prog_data_in,
    output logic [ADDR_WIDTH-1:0]   prog_addr,
    output logic                    prog_write_enable,
    output logic                    start_execution,
    output logic                    busy,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     words_loaded
);

    state_e                  state_q, state_d;
    logic [HEADER_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0]   index_q, index_d;
    logic [7:0]              hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     words_q, words_d;
    logic                    error_q, error_d;
    logic                    accept;

    assign accept = byte_valid && byte_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            words_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        hi_d    = hi_q;
        data_d  = data_q;
        addr_d  = addr_q;
        words_d = words_q;
        error_d = error_q;
        case (state_q)
            IDLE: if (accept) begin
                count_d = byte_in;
                if (byte_in != '0 && byte_in <= HEADER_WIDTH'(MAX_WORDS)) begin
                    state_d = HI;
                    index_d = '0;
                    words_d = '0;
                end else begin
                    state_d = ERR;
                    error_d = 1'b1;
                end
            end
            HI: if (accept) begin
                hi_d    = byte_in;
                state_d = LO;
            end
            LO: if (accept) begin
                data_d  = {hi_q, byte_in};
                addr_d  = index_q;
                state_d = WRITE;
            end
            WRITE: begin
                words_d = words_q + (ADDR_WIDTH + 1)'(1);
                // Compare at header width so count=32 never aliases a 5-bit index.
                if (HEADER_WIDTH'(index_q) == count_q - HEADER_WIDTH'(1)) begin
                    state_d = WAIT_DONE;
                end else begin
                    index_d = index_q + ADDR_WIDTH'(1);
                    state_d = HI;
                end
            end
            WAIT_DONE: if (load_done) state_d = START;
            START:     state_d = IDLE;
            ERR:       state_d = ERR;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready        = 1'b0;
        prog_write_enable = 1'b0;
        start_execution   = 1'b0;
        busy              = (state_q != IDLE);
        case (state_q)
            IDLE, HI, LO, ERR: byte_ready        = 1'b1;
            WRITE:             prog_write_enable = 1'b1;
            START:             start_execution   = 1'b1;
            default:           byte_ready        = 1'b0;
        endcase
    end

    assign prog_data_in = data_q;
    assign prog_addr    = addr_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_stream_receiver.sv
// Scoreboard bench: stimulus pushes expected writes/starts, a negedge monitor checks them.
module tb_program_stream_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        load_done = 1'b1;
    logic [15:0] prog_data_in;
    logic [4:0]  prog_addr;
    logic        prog_write_enable;
    logic        start_execution;
    logic        busy;
    logic        error;
    logic [5:0]  words_loaded;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_exp = 0;
    logic [20:0] wr_q[$];
    int          wr_cyc[$];

    program_stream_receiver dut (
        .clock            (clock),
        .reset            (reset),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .load_done        (load_done),
        .prog_data_in     (prog_data_in),
        .prog_addr        (prog_addr),
        .prog_write_enable(prog_write_enable),
        .start_execution  (start_execution),
        .busy             (busy),
        .error            (error),
        .words_loaded     (words_loaded)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write; starts must be expected.
    always @(negedge clock) begin
        if (!reset) begin
            if (prog_write_enable && start_execution)
                chk("wr_and_start_overlap", 1, 0);
            if (prog_write_enable) begin
                wr_cyc.push_back(cyc);
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {11'b0, prog_addr, prog_data_in}, 0);
                end else begin
                    logic [20:0] e;
                    e = wr_q.pop_front();
                    chk("write_addr", prog_addr, e[20:16]);
                    chk("write_data", prog_data_in, e[15:0]);
                end
            end
            if (start_execution) begin
                chk("start_expected", (start_exp > 0), 1);
                if (start_exp > 0) start_exp--;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        @(negedge clock);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!byte_ready) begin
            chk("byte_accept_timeout", 0, 1);
        end else begin
            @(posedge clock);
        end
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
        send_byte(w[15:8]);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
        send_byte(w[7:0]);
    endtask

    task automatic wait_start(input int unsigned limit);
        int unsigned n = 0;
        @(negedge clock);
        while (!start_execution && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk("start_seen", start_execution, 1);
        @(negedge clock);
        chk("idle_after_start_busy", busy, 0);
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [15:0] rnd_words [3];
        rnd_words[0] = 16'h0102;
        rnd_words[1] = 16'hA5A5;
        rnd_words[2] = 16'hFFEE;

        // Reset values
        #12;
        chk("rst_byte_ready", byte_ready, 1);
        chk("rst_pwe", prog_write_enable, 0);
        chk("rst_start", start_execution, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_data", prog_data_in, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_words", words_loaded, 0);
        @(negedge clock);
        reset = 1'b0;

        // Two words at full rate, load_done tied high
        load_done = 1'b1;
        wr_cyc.delete();
        wr_q.push_back({5'd0, 16'h1234});
        wr_q.push_back({5'd1, 16'hABCD});
        start_exp = 1;
        send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        wait_start(20);
        chk("t1_words_loaded", words_loaded, 2);
        chk("t1_strobe_gap", (wr_cyc.size() == 2) ? wr_cyc[1] - wr_cyc[0] : -1, 3);
        chk("t1_hold_addr", prog_addr, 1);
        chk("t1_hold_data", prog_data_in, 16'hABCD);

        // Bad headers: zero and one-past-maximum
        send_byte(8'h00);
        chk("t2a_error", error, 1);
        chk("t2a_busy", busy, 1);
        chk("t2a_ready", byte_ready, 1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        repeat (5) @(negedge clock);
        chk("t2a_error_sticky", error, 1);
        do_reset();
        chk("t2_error_cleared", error, 0);
        send_byte(8'h21);
        chk("t2b_error", error, 1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        repeat (5) @(negedge clock);
        chk("t2b_error_sticky", error, 1);
        chk("t2b_words", words_loaded, 0);
        do_reset();

        // Maximum count: 32 words, data = addr * 0x0101
        for (int i = 0; i < 32; i++) wr_q.push_back({5'(i), 8'(i), 8'(i)});
        start_exp = 1;
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) send_word({8'(i), 8'(i)}, 1'b0);
        wait_start(20);
        chk("t3_words_loaded", words_loaded, 32);
        chk("t3_last_addr", prog_addr, 31);
        chk("t3_last_data", prog_data_in, 16'h1F1F);

        // load_done held low for 10 cycles
        load_done = 1'b0;
        wr_q.push_back({5'd0, 16'h5555});
        start_exp = 1;
        send_byte(8'h01);
        send_word(16'h5555, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t4_no_start", start_execution, 0);
            chk("t4_not_ready", byte_ready, 0);
        end
        load_done = 1'b1;
        @(negedge clock);
        chk("t4_start_next_cycle", start_execution, 1);
        @(negedge clock);
        chk("t4_start_one_cycle", start_execution, 0);
        chk("t4_idle", busy, 0);

        // Random byte_valid gaps
        for (int i = 0; i < 3; i++) wr_q.push_back({5'(i), rnd_words[i]});
        start_exp = 1;
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            w = rnd_words[i];
            send_word(w, 1'b1);
        end
        wait_start(20);
        chk("t5_words_loaded", words_loaded, 3);

        // Reset after the high byte of word 1
        wr_q.push_back({5'd0, 16'h1111});
        send_byte(8'h02);
        send_word(16'h1111, 1'b0);
        send_byte(8'h22);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_ready", byte_ready, 1);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_data", prog_data_in, 0);
        chk("t6_async_addr", prog_addr, 0);
        chk("t6_async_words", words_loaded, 0);
        chk("t6_async_pwe", prog_write_enable, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wr_q.push_back({5'd0, 16'hBEEF});
        start_exp = 1;
        send_byte(8'h01);
        send_word(16'hBEEF, 1'b0);
        wait_start(20);
        chk("t6_words_loaded", words_loaded, 1);

        repeat (3) @(negedge clock);
        chk("pending_writes", wr_q.size(), 0);
        chk("pending_starts", start_exp, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
